// File: rtl/cpu_mult_pipe_if.sv
// Request/response bundle for the pipelined multiplier: operands, sideband tag,
// pipeline control (stall/flush) and the completion side.
interface cpu_mult_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             in_valid;
  logic             stall;
  logic             flush;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             sign1;
  logic             sign2;
  logic             hi_sel;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output in_valid, stall, flush, src1, src2, sign1, sign2, hi_sel, in_tag,
    input  out_valid, result, out_tag, busy
  );

  modport slave (
    input  in_valid, stall, flush, src1, src2, sign1, sign2, hi_sel, in_tag,
    output out_valid, result, out_tag, busy
  );
endinterface

// File: rtl/cpu_mult_pipe.sv
// Pipelined WIDTH x WIDTH multiplier with per-operand signedness, hi/lo half select
// and a tag carried alongside; global stall and flush, latency 2+OUT_REG.
module cpu_mult_pipe #(
  parameter int WIDTH   = 32,
  parameter int OUT_REG = 1,
  parameter int TAG_W   = 5
) (
  input logic            clk,
  input logic            reset_n,
  cpu_mult_pipe_if.slave bus
);
  localparam int H   = WIDTH / 2;
  localparam int PW  = 2 * WIDTH;
  localparam int PPW = WIDTH + 2;

  // Each operand is split into an unsigned low half and a (H+1)-bit high half that
  // carries the sign/zero extension, so all four partial products are signed.
  logic sgn1, sgn2;
  assign sgn1 = bus.sign1 & bus.src1[WIDTH-1];
  assign sgn2 = bus.sign2 & bus.src2[WIDTH-1];

  logic signed [PPW-1:0] a_ext   [2];
  logic signed [PPW-1:0] b_ext   [2];
  logic signed [PPW-1:0] pp_next [4];
  logic signed [PPW-1:0] pp_reg  [4];

  assign a_ext[0] = {{(PPW-H){1'b0}}, bus.src1[H-1:0]};
  assign a_ext[1] = {{(PPW-H){sgn1}}, bus.src1[WIDTH-1:H]};
  assign b_ext[0] = {{(PPW-H){1'b0}}, bus.src2[H-1:0]};
  assign b_ext[1] = {{(PPW-H){sgn2}}, bus.src2[WIDTH-1:H]};

  genvar gi, gj;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pp_row
      for (gj = 0; gj < 2; gj++) begin : g_pp_col
        assign pp_next[gi*2+gj] = a_ext[gi] * b_ext[gj];
      end
    end
  endgenerate

  logic             s1_hi_sel_reg;
  logic [TAG_W-1:0] s1_tag_reg;
  logic             s1_valid_reg;
  logic [WIDTH-1:0] s2_data_reg;
  logic [TAG_W-1:0] s2_tag_reg;
  logic             s2_valid_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) pp_reg[k] <= '0;
      s1_hi_sel_reg <= 1'b0;
      s1_tag_reg    <= '0;
    end else if (!bus.stall) begin
      for (int k = 0; k < 4; k++) pp_reg[k] <= pp_next[k];
      s1_hi_sel_reg <= bus.hi_sel;
      s1_tag_reg    <= bus.in_tag;
    end
  end

  // Sign-extended partial products summed modulo 2^PW give the exact product.
  logic signed [PW-1:0] sum_next;
  logic [WIDTH-1:0]     s2_data_next;

  always_comb begin
    sum_next = '0;
    for (int k = 0; k < 4; k++) begin
      sum_next = sum_next + (PW'(pp_reg[k]) << (((k >> 1) + (k & 1)) * H));
    end
    s2_data_next = s1_hi_sel_reg ? sum_next[PW-1:WIDTH] : sum_next[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_data_reg <= '0;
      s2_tag_reg  <= '0;
    end else if (!bus.stall) begin
      s2_data_reg <= s2_data_next;
      s2_tag_reg  <= s1_tag_reg;
    end
  end

  // Flush wins over stall so a frozen pipeline can still be emptied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else if (bus.flush) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else if (!bus.stall) begin
      s1_valid_reg <= bus.in_valid;
      s2_valid_reg <= s1_valid_reg;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] out_data_reg;
      logic [TAG_W-1:0] out_tag_reg;
      logic             out_valid_reg;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_data_reg <= '0;
          out_tag_reg  <= '0;
        end else if (!bus.stall) begin
          out_data_reg <= s2_data_reg;
          out_tag_reg  <= s2_tag_reg;
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          out_valid_reg <= 1'b0;
        end else if (bus.flush) begin
          out_valid_reg <= 1'b0;
        end else if (!bus.stall) begin
          out_valid_reg <= s2_valid_reg;
        end
      end

      assign bus.out_valid = out_valid_reg;
      assign bus.result    = out_valid_reg ? out_data_reg : '0;
      assign bus.out_tag   = out_tag_reg;
      assign bus.busy      = s1_valid_reg | s2_valid_reg;
    end else begin : g_out_comb
      assign bus.out_valid = s2_valid_reg;
      assign bus.result    = s2_valid_reg ? s2_data_reg : '0;
      assign bus.out_tag   = s2_tag_reg;
      assign bus.busy      = s1_valid_reg;
    end
  endgenerate
endmodule
